barrel_fetch: RTL

BARREL_FETCH -- requirements
Module: barrel_fetch

---
 rtl/barrel_fetch.sv | 128 ++++++++++++
 1 files changed

// File: rtl/barrel_fetch.sv
// barrel_fetch: fetch stage of a barrel (fine-grained multithreaded) processor.
// One hardware thread is fetched per cycle in strict round-robin order; each
// thread keeps its own PC. Instruction memory is read combinationally through
// imem_addr/imem_rdata and the issued slot is registered into the *_f outputs.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   stall_f         freeze thread pointer, fetch outputs and non-redirected PCs
//   redirect_e      taken branch/jump from execute for thread redirect_tid_e
//   redirect_tid_e  thread owning the redirect
//   pc_target_e     redirect target (bits [1:0] are dropped)
//   thread_en       per-thread enable (only with BARREL_FETCH_THREAD_MASK_EN)
//   imem_addr       instruction-memory address = pc[sel]
//   imem_rdata      instruction-memory data for imem_addr
//   pc_f, pc_plus4_f, instr_f, tid_f, valid_f  registered issued slot
//
// Optional feature: define BARREL_FETCH_THREAD_MASK_EN to add the thread_en
// input; a disabled thread's slot issues a bubble and its PC does not advance.
module barrel_fetch #(
  parameter int unsigned               ADDRESS_WIDTH = 32,
  parameter int unsigned               DATA_WIDTH    = 32,
  parameter int unsigned               NUM_THREADS   = 8,
  parameter int unsigned               BITS_THREADS  = $clog2(NUM_THREADS),
  parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_f,
  input  logic                     redirect_e,
  input  logic [BITS_THREADS-1:0]  redirect_tid_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
`ifdef BARREL_FETCH_THREAD_MASK_EN
  input  logic [NUM_THREADS-1:0]   thread_en,
`endif
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic [BITS_THREADS-1:0]  tid_f,
  output logic                     valid_f
);

  // addi x0, x0, 0 -- canonical NOP carried by bubble slots
  localparam logic [DATA_WIDTH-1:0]   Nop     = DATA_WIDTH'(32'h0000_0013);
  localparam logic [BITS_THREADS-1:0] LastTid = BITS_THREADS'(NUM_THREADS - 1);

  logic [ADDRESS_WIDTH-1:0] r_pc [NUM_THREADS];
  logic [BITS_THREADS-1:0]  r_sel;
  logic [ADDRESS_WIDTH-1:0] r_pc_f;
  logic [ADDRESS_WIDTH-1:0] r_pc_plus4_f;
  logic [DATA_WIDTH-1:0]    r_instr_f;
  logic [BITS_THREADS-1:0]  r_tid_f;
  logic                     r_valid_f;

  logic [ADDRESS_WIDTH-1:0] w_pc_d [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] w_pc_cur;
  logic [ADDRESS_WIDTH-1:0] w_pc_plus4;
  logic [ADDRESS_WIDTH-1:0] w_target;
  logic [BITS_THREADS-1:0]  w_sel_next;
  logic                     w_redir_ok;
  logic                     w_collide;
  logic                     w_en;
  logic                     w_issue;

`ifdef BARREL_FETCH_THREAD_MASK_EN
  assign w_en = thread_en[r_sel];
`else
  assign w_en = 1'b1;
`endif

  assign w_pc_cur   = r_pc[r_sel];
  assign w_pc_plus4 = w_pc_cur + ADDRESS_WIDTH'(4);
  assign imem_addr  = w_pc_cur;
  assign w_target   = {pc_target_e[ADDRESS_WIDTH-1:2], 2'b00};
  // Out-of-range thread ids only exist for non-power-of-two thread counts.
  assign w_redir_ok = redirect_e && (32'(redirect_tid_e) < NUM_THREADS);
  assign w_collide  = w_redir_ok && (redirect_tid_e == r_sel) && !stall_f;
  // A real instruction leaves this cycle: not stalled, not overridden, enabled.
  assign w_issue    = !stall_f && !w_collide && w_en;
  assign w_sel_next = (r_sel == LastTid) ? '0 : r_sel + BITS_THREADS'(1);

  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_pc_d[i] = r_pc[i];
    end
    if (w_issue) begin
      w_pc_d[r_sel] = w_pc_plus4;
    end
    // Redirect is applied last so it wins over the sequential increment.
    if (w_redir_ok) begin
      w_pc_d[redirect_tid_e] = w_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        r_pc[i] <= RESET_PC;
      end
      r_sel        <= '0;
      r_pc_f       <= '0;
      r_pc_plus4_f <= '0;
      r_instr_f    <= Nop;
      r_tid_f      <= '0;
      r_valid_f    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        r_pc[i] <= w_pc_d[i];
      end
      if (!stall_f) begin
        r_sel        <= w_sel_next;
        r_pc_f       <= w_pc_cur;
        r_pc_plus4_f <= w_pc_plus4;
        r_instr_f    <= w_issue ? imem_rdata : Nop;
        r_tid_f      <= r_sel;
        r_valid_f    <= w_issue;
      end
    end
  end

  assign pc_f       = r_pc_f;
  assign pc_plus4_f = r_pc_plus4_f;
  assign instr_f    = r_instr_f;
  assign tid_f      = r_tid_f;
  assign valid_f    = r_valid_f;

endmodule
